// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window,
// emitting one 72-bit window per interior pixel through a single ready/valid output register.
module window_gen_3x3 #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [7:0]  in_pixel,
  input  logic        in_sof,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [71:0] out_window,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {FILL, RUN} state_t;

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_lb1 [WIDTH];
  logic [7:0]      r_lb2 [WIDTH];
  logic [2:0][7:0] r_top, r_mid, r_bot;
  logic [71:0]     r_out_window;
  logic            r_out_valid;
  logic            r_frame_done;

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  state_t          w_state;
  logic            w_accept;
  logic            w_emit;
  logic            w_col_last;
  logic            w_row_last;
  logic [7:0]      w_lb1_rd;
  logic [7:0]      w_lb2_rd;
  logic [2:0][7:0] w_top_next, w_mid_next, w_bot_next;

  assign in_ready   = !r_out_valid | out_ready;
  assign w_accept   = in_valid & in_ready;

  // A start-of-frame pixel is (0,0) no matter where the counters stand.
  assign w_col      = in_sof ? '0 : r_col;
  assign w_row      = in_sof ? '0 : r_row;
  assign w_state    = (w_row >= RW'(2)) ? RUN : FILL;
  assign w_emit     = w_accept && (w_state == RUN) && (w_col >= CW'(2));
  assign w_col_last = (w_col == COL_LAST);
  assign w_row_last = (w_row == ROW_LAST);

  assign w_lb1_rd   = r_lb1[w_col];
  assign w_lb2_rd   = r_lb2[w_col];

  // Index [0] is column c-2, index [2] is column c (the newest pixel).
  assign w_top_next = {w_lb2_rd, r_top[2], r_top[1]};
  assign w_mid_next = {w_lb1_rd, r_mid[2], r_mid[1]};
  assign w_bot_next = {in_pixel, r_bot[2], r_bot[1]};

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept & w_col_last & w_row_last;
      if (w_accept) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
      if (w_emit) begin
        r_out_window <= {w_bot_next, w_mid_next, w_top_next};
        r_out_valid  <= 1'b1;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // NOTE: line buffers and window registers are not reset; position counters gate their validity.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb2[w_col] <= w_lb1_rd;
      r_lb1[w_col] <= in_pixel;
      r_top        <= w_top_next;
      r_mid        <= w_mid_next;
      r_bot        <= w_bot_next;
    end
  end

  assign out_window = r_out_window;
  assign out_valid  = r_out_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Self-checking bench for window_gen_3x3 on a 4x4 frame: vector table for the first frame,
// then an image-model scoreboard for stalls, back-to-back frames, mid-frame sof, reset and gaps.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [7:0]  in_pixel;
  logic        in_sof;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] out_window;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;

  window_gen_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_window (out_window),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [71:0] FIRST_WIN_0  = 72'h22_21_20_12_11_10_02_01_00;
  localparam logic [71:0] FIRST_WIN_80 = 72'hA2_A1_A0_92_91_90_82_81_80;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a full image of the current frame plus expected-window queue.
  logic [7:0]  img [H][W];
  int          m_r = 0;
  int          m_c = 0;
  bit          m_ov = 1'b0;
  bit          m_fd = 1'b0;
  bit          last_acc;
  logic [71:0] sb_q [$];
  int          n_win = 0;
  int          n_fd  = 0;

  typedef struct {
    logic [7:0]  pix;
    bit          sof;
    bit          exp_ov;
    logic [71:0] exp_win;
  } vec_t;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit v, input bit sof, input logic [7:0] pix, input bit rdy);
    int  r;
    int  c;
    bit  acc;
    bit  emit;
    @(negedge clk);
    in_valid  = v;
    in_sof    = sof;
    in_pixel  = pix;
    out_ready = rdy;
    #1;
    check("in_ready", in_ready, (!m_ov || rdy));
    if (m_ov && rdy) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL window: DUT offered %h with nothing expected", out_window);
      end else begin
        check("window", out_window, sb_q.pop_front());
        n_win++;
      end
    end
    acc  = v && (!m_ov || rdy);
    emit = 1'b0;
    m_fd = 1'b0;
    if (acc) begin
      r = sof ? 0 : m_r;
      c = sof ? 0 : m_c;
      img[r][c] = pix;
      if (r >= 2 && c >= 2) begin
        emit = 1'b1;
        sb_q.push_back({img[r][c],   img[r][c-1],   img[r][c-2],
                        img[r-1][c], img[r-1][c-1], img[r-1][c-2],
                        img[r-2][c], img[r-2][c-1], img[r-2][c-2]});
      end
      m_fd = (r == H-1) && (c == W-1);
      if (c == W-1) begin
        m_c = 0;
        m_r = (r == H-1) ? 0 : r + 1;
      end else begin
        m_c = c + 1;
        m_r = r;
      end
    end
    if (emit)     m_ov = 1'b1;
    else if (rdy) m_ov = 1'b0;
    last_acc = acc;
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    check("frame_done", frame_done, m_fd);
    if (frame_done) n_fd++;
  endtask

  task automatic send(input logic [7:0] pix, input bit sof, input bit rdy);
    int tries = 0;
    do begin
      step(1'b1, sof, pix, rdy);
      tries++;
    end while (!last_acc && tries < 10);
    if (!last_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept: pixel %h not taken within 10 cycles", pix);
    end
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gap, input bit stall,
                            input bit use_sof, input logic [71:0] exp_first);
    int w0 = n_win;
    int f0 = n_fd;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap) step(1'b0, 1'b0, 8'h00, 1'b1);
        send(base + 8'(16*r + c), use_sof && r == 0 && c == 0, 1'b1);
        if (r == 2 && c == 2) begin
          check("first_window", out_window, exp_first);
          if (stall) begin
            repeat (5) step(1'b1, 1'b0, base + 8'(16*r + c + 1), 1'b0);
            check("stall_hold_window", out_window, exp_first);
          end
        end
      end
    end
    drain();
    check("windows_per_frame", 72'(n_win - w0), 72'd4);
    check("frame_done_pulses", 72'(n_fd - f0), 72'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_out_window", out_window, 72'h0);
    check("rst_in_ready", in_ready, 1'b1);
    m_r  = 0;
    m_c  = 0;
    m_ov = 1'b0;
    m_fd = 1'b0;
    sb_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin
    vec_t        tbl [W*H];
    logic [71:0] wins [4];
    int          w0;
    int          f0;

    n_rst     = 1'b0;
    in_pixel  = 8'h00;
    in_sof    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    wins[0] = 72'h22_21_20_12_11_10_02_01_00;
    wins[1] = 72'h23_22_21_13_12_11_03_02_01;
    wins[2] = 72'h32_31_30_22_21_20_12_11_10;
    wins[3] = 72'h33_32_31_23_22_21_13_12_11;
    for (int i = 0; i < W*H; i++) begin
      tbl[i].pix     = 8'(16*(i / W) + (i % W));
      tbl[i].sof     = (i == 0);
      tbl[i].exp_ov  = (i / W >= 2) && (i % W >= 2);
      tbl[i].exp_win = tbl[i].exp_ov ? wins[(i / W - 2) * 2 + (i % W - 2)] : 72'h0;
    end

    reset_dut();

    // Frame 1 against the hand-built vector table.
    w0 = n_win;
    f0 = n_fd;
    for (int i = 0; i < W*H; i++) begin
      send(tbl[i].pix, tbl[i].sof, 1'b1);
      check("tbl_out_valid", out_valid, tbl[i].exp_ov);
      if (tbl[i].exp_ov) check("tbl_out_window", out_window, tbl[i].exp_win);
    end
    drain();
    check("tbl_windows", 72'(n_win - w0), 72'd4);
    check("tbl_frame_done", 72'(n_fd - f0), 72'd1);

    // Downstream stall of five cycles after the first window.
    send_frame(8'h00, 1'b0, 1'b1, 1'b1, FIRST_WIN_0);

    // Back-to-back frames, second offset by 0x80.
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, FIRST_WIN_0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, FIRST_WIN_80);

    // Start of frame arriving where (2,1) would have been.
    w0 = n_win;
    for (int i = 0; i < 2*W + 1; i++) send(8'h40 + 8'(16*(i / W) + (i % W)), i == 0, 1'b1);
    drain();
    check("pre_sof_windows", 72'(n_win - w0), 72'd0);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, FIRST_WIN_80);

    // Reset mid row 2 with a window pending, then a frame without sof.
    for (int i = 0; i < 2*W + 3; i++) send(8'h40 + 8'(16*(i / W) + (i % W)), i == 0, 1'b1);
    check("pre_reset_valid", out_valid, 1'b1);
    reset_dut();
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, FIRST_WIN_0);

    // Input bubbles every other cycle.
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, FIRST_WIN_0);

    check("queue_empty", 72'(sb_q.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator that sits directly upstream of the arithmetic (Laplacian) stage. It accepts one 8-bit grayscale pixel per cycle in raster order, keeps the two previous image rows in line buffers, and presents each complete 3x3 window as a 72-bit word in the register layout the arithmetic stage consumes. Windows are emitted only when all nine pixels lie inside the current frame; border positions produce no output.

## Interface
- WIDTH, 640, pixels per row (≥3); column counter and line-buffer depth.
- HEIGHT, 480, rows per frame (≥3).
- clk  in  1  clock, all logic on rising edge.
- n_rst  in  1  synchronous, active-low reset.
- in_pixel  in  8  input pixel, raster order.
- in_sof  in  1  start of frame, qualified by in_valid; the pixel carrying it is (row 0, col 0).
- in_valid  in  1  in_pixel/in_sof valid.
- in_ready  out  1  block can accept a pixel this cycle.
- out_window  out  72  3x3 window: [7:0] reg0 … [71:64] reg8.
- out_valid  out  1  out_window valid.
- out_ready  in  1  downstream accepts out_window this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame (row HEIGHT-1, col WIDTH-1) is accepted.

## Operation
- Accept = in_valid & in_ready. Nothing changes on cycles without accept, except output drain.
- in_ready = !out_valid | out_ready (single output register, combinational ready).
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the pixel being accepted. On accept: col wraps to 0 at WIDTH-1 and row increments; row wraps to 0 after (HEIGHT-1, WIDTH-1) and frame_done pulses next cycle.
- Accept with in_sof=1: pixel is treated as (0,0) regardless of counters; counters restart from it; window shift registers are logically discarded (no window emitted until valid again).
- Line buffers: LB1 holds row r-1, LB2 holds row r-2, each WIDTH×8. On accept at column c: read LB1[c], LB2[c]; write LB2[c]←LB1[c], LB1[c]←in_pixel. Contents not reset; validity is gated by counters.
- Window shift registers: three rows × three columns; on accept each row shifts left and loads (LB2[c], LB1[c], in_pixel) into the rightmost column.
- Window layout for accepted pixel at (r,c): reg0..reg2 = row r-2, cols c-2..c; reg3..reg5 = row r-1; reg6..reg8 = row r. reg4 (center) is pixel (r-1,c-1).
- A window is emitted iff the accepted pixel has r≥2 and c≥2 (and counters not invalidated by in_sof on this same pixel unless it is itself (0,0) — which never emits). Windows per frame: (HEIGHT-2)×(WIDTH-2).
- Output register: loads out_window and sets out_valid on an emitting accept; clears out_valid when out_ready=1 and no new emitting accept. Held stable while out_valid & !out_ready.
- States (derived from row): FILL (row<2, no output), RUN (row≥2, output when c≥2). Frame boundary returns to FILL.

## Timing
- Reset (n_rst=0 at rising edge): col=0, row=0, out_valid=0, out_window=0, frame_done=0; in_ready=1 after reset.
- Latency: window for pixel accepted at edge N is on out_window with out_valid=1 from edge N until consumed. Throughput one pixel/window per cycle with out_ready held 1.
- Simultaneous drain and emitting accept in same cycle: out_window replaced, out_valid stays 1.
- Reset mid-frame: discards out_valid and position; next pixel is (0,0) even without in_sof.
- frame_done high exactly one cycle, the cycle after the final accept.

## Test plan
- WIDTH=4, HEIGHT=4, pixel = 16·row+col, out_ready=1: first out_valid after accepting (2,2), out_window=72'h22_21_20_12_11_10_02_01_00; exactly 4 windows per frame; frame_done pulses once after (3,3).
- Same stimulus, out_ready=0 for 5 cycles after first window: out_window/out_valid hold, in_ready=0, in_valid pixels not accepted; resumes with no lost or duplicated windows.
- Two back-to-back frames, second starting with in_sof: second frame’s first window again 72'h22_21_20_12_11_10_02_01_00 (values +0x80 if frame 2 adds 0x80: 72'hA2_A1_A0_92_91_90_82_81_80).
- in_sof asserted at (2,1) mid-frame: no window until new row 2 col 2; next window built only from new-frame pixels.
- n_rst low mid-row 2 with out_valid=1: next cycle out_valid=0, frame_done=0, out_window=0; following pixels treated from (0,0).
- in_valid gaps (valid every other cycle): same window values and count as continuous stream.
